// File: rtl/tape_unit.sv
// Tape storage and head controller: holds DEPTH 3-bit symbols, applies one write/move step per cycle,
// and accepts a host-side tape load. Define TAPE_WRAP_EN for a circular tape (no edge fault).
module tape_unit #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [2:0]        load_sym,
    output logic              load_ready,
    input  logic              step_valid,
    input  logic [2:0]        wr_sym,
    input  logic [1:0]        move,
    output logic              step_ready,
    output logic              s2,
    output logic              s1,
    output logic              s0,
    output logic [ADDR_W-1:0] head,
    output logic              edge_fault,
    output logic [15:0]       step_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [1:0]        MOVE_RIGHT = 2'b01;
    localparam logic [1:0]        MOVE_LEFT  = 2'b10;
    localparam logic [ADDR_W:0]   WPTR_END   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] HEAD_MAX   = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   head_q, head_d;
    logic [ADDR_W:0]     wptr_q, wptr_d;
    logic [15:0]         count_q, count_d;
    logic [2:0]          sym_q, sym_d;
    logic [2:0]          cells_q [DEPTH];
    logic [2:0]          cells_d [DEPTH];
    logic                enter_load;
    logic                edge_hit;
    logic                step_fire;
    logic                load_fire;

    // Ready strobes are combinational; gating with rst_n keeps them low while reset is held.
    assign step_ready = rst_n && (state_q == ST_RUN) && !load_en;
    assign load_ready = rst_n && (state_q == ST_LOAD) && (wptr_q < WPTR_END);
    assign step_fire  = step_valid && step_ready;
    assign load_fire  = load_valid && load_ready;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d    = state_q;
        head_d     = head_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        cells_d    = cells_q;
        enter_load = 1'b0;
        edge_hit   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (load_en) begin
                    enter_load = 1'b1;
                end else if (step_fire) begin
                    cells_d[head_q] = wr_sym;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (move == MOVE_RIGHT) begin
                        if (head_q == HEAD_MAX) begin
`ifdef TAPE_WRAP_EN
                            head_d = '0;
`else
                            edge_hit = 1'b1;
`endif
                        end else begin
                            head_d = head_q + 1'b1;
                        end
                    end else if (move == MOVE_LEFT) begin
                        if (head_q == '0) begin
`ifdef TAPE_WRAP_EN
                            head_d = HEAD_MAX;
`else
                            edge_hit = 1'b1;
`endif
                        end else begin
                            head_d = head_q - 1'b1;
                        end
                    end
                    if (edge_hit) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_LOAD: begin
                if (load_fire) begin
                    cells_d[wptr_q[ADDR_W-1:0]] = load_sym;
                    wptr_d = wptr_q + 1'b1;
                end
                if (!load_en) begin
                    head_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (load_en) begin
                    enter_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (enter_load) begin
            state_d = ST_LOAD;
            wptr_d  = '0;
            count_d = '0;
        end

        // Symbol register tracks the post-update cell under the post-update head.
        sym_d = cells_d[head_d];
    end

    // NOTE: the tape is reset cell by cell on purpose (reset must clear it), so it maps to flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            sym_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cells_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            sym_q   <= sym_d;
            cells_q <= cells_d;
        end
    end

`ifdef TAPE_WRAP_EN
    assign edge_fault = 1'b0;
`else
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (enter_load) begin
            fault_d = 1'b0;
        end else if (edge_hit) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign edge_fault = fault_q;
`endif

    assign s2         = sym_q[2];
    assign s1         = sym_q[1];
    assign s0         = sym_q[0];
    assign head       = head_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_tape_unit.sv
// Directed testbench for tape_unit: load, step, arbitration, edge handling and reset-mid-load.
module tb_tape_unit;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              load_en;
    logic              load_valid;
    logic [2:0]        load_sym;
    logic              load_ready;
    logic              step_valid;
    logic [2:0]        wr_sym;
    logic [1:0]        move;
    logic              step_ready;
    logic              s2, s1, s0;
    logic [ADDR_W-1:0] head;
    logic              edge_fault;
    logic [15:0]       step_count;

    int n_checks = 0;
    int n_errors = 0;

    tape_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_valid (load_valid),
        .load_sym   (load_sym),
        .load_ready (load_ready),
        .step_valid (step_valid),
        .wr_sym     (wr_sym),
        .move       (move),
        .step_ready (step_ready),
        .s2         (s2),
        .s1         (s1),
        .s0         (s0),
        .head       (head),
        .edge_fault (edge_fault),
        .step_count (step_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pat(input int i);
        return 3'((i * 3 + 1) % 8);
    endfunction

    initial begin
        logic [2:0] any_cell;

        rst_n      = 1'b0;
        load_en    = 1'b0;
        load_valid = 1'b0;
        load_sym   = 3'd0;
        step_valid = 1'b0;
        wr_sym     = 3'd0;
        move       = 2'b00;

        // Reset held
        #1;
        check("rst_step_ready", 32'(step_ready), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("idle_sym", 32'({s2, s1, s0}), 32'd0);
        check("idle_head", 32'(head), 32'd0);
        check("idle_count", 32'(step_count), 32'd0);
        check("idle_step_ready", 32'(step_ready), 32'd1);
        check("idle_load_ready", 32'(load_ready), 32'd0);
        check("idle_fault", 32'(edge_fault), 32'd0);

        // Load 001,010,100 then return to RUN
        load_en = 1'b1;
        tick();
        check("load_ready_on", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_sym = 3'b001; tick();
        load_sym = 3'b010; tick();
        load_sym = 3'b100; tick();
        load_valid = 1'b0;
        load_en = 1'b0;
        tick();
        check("exit_head", 32'(head), 32'd0);
        check("exit_sym", 32'({s2, s1, s0}), 32'b001);
        check("exit_step_ready", 32'(step_ready), 32'd1);
        check("unwritten_cell3", 32'(dut.cells_q[3]), 32'd0);

        // First step: write 111, move right
        step_valid = 1'b1; wr_sym = 3'b111; move = 2'b01;
        tick();
        check("s1_head", 32'(head), 32'd1);
        check("s1_sym", 32'({s2, s1, s0}), 32'b010);
        check("s1_cell0", 32'(dut.cells_q[0]), 32'b111);
        check("s1_count", 32'(step_count), 32'd1);

        // Back-to-back: stay, right, stay(11)
        wr_sym = 3'b101; move = 2'b00; tick();
        check("stay_sym", 32'({s2, s1, s0}), 32'b101);
        check("stay_head", 32'(head), 32'd1);
        check("stay_count", 32'(step_count), 32'd2);
        wr_sym = 3'b011; move = 2'b01; tick();
        check("b2b_head", 32'(head), 32'd2);
        check("b2b_sym", 32'({s2, s1, s0}), 32'b100);
        check("b2b_count", 32'(step_count), 32'd3);
        wr_sym = 3'b110; move = 2'b11; tick();
        check("stay11_sym", 32'({s2, s1, s0}), 32'b110);
        check("stay11_head", 32'(head), 32'd2);
        check("stay11_count", 32'(step_count), 32'd4);
        step_valid = 1'b0; tick();
        check("idle_hold_count", 32'(step_count), 32'd4);

        // Load wins over simultaneous step
        load_en = 1'b1; step_valid = 1'b1; wr_sym = 3'b111; move = 2'b01;
        #1;
        check("arb_step_ready", 32'(step_ready), 32'd0);
        tick();
        step_valid = 1'b0;
        check("arb_count", 32'(step_count), 32'd0);
        check("arb_cell2", 32'(dut.cells_q[2]), 32'b110);
        check("arb_head", 32'(head), 32'd2);
        check("arb_load_ready", 32'(load_ready), 32'd1);

        // Overfill: DEPTH+2 symbols, last two ignored
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_valid = 1'b1;
            load_sym   = pat(i);
            #1;
            check($sformatf("fill_ready_%0d", i), 32'(load_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            tick();
        end
        load_valid = 1'b0;
        check("fill_cell0", 32'(dut.cells_q[0]), 32'(pat(0)));
        check("fill_cell7", 32'(dut.cells_q[7]), 32'(pat(7)));
        check("fill_cell15", 32'(dut.cells_q[15]), 32'(pat(15)));
        load_en = 1'b0;
        tick();
        check("fill_exit_head", 32'(head), 32'd0);
        check("fill_exit_sym", 32'({s2, s1, s0}), 32'(pat(0)));

        // Left edge at head 0
        step_valid = 1'b1; wr_sym = 3'b101; move = 2'b10;
        tick();
        step_valid = 1'b0;
        #1;
        check("ledge_cell0", 32'(dut.cells_q[0]), 32'b101);
        check("ledge_count", 32'(step_count), 32'd1);
`ifdef TAPE_WRAP_EN
        check("ledge_head", 32'(head), 32'(DEPTH - 1));
        check("ledge_fault", 32'(edge_fault), 32'd0);
        check("ledge_sym", 32'({s2, s1, s0}), 32'(pat(15)));
        check("ledge_step_ready", 32'(step_ready), 32'd1);
`else
        check("ledge_head", 32'(head), 32'd0);
        check("ledge_fault", 32'(edge_fault), 32'd1);
        check("ledge_sym", 32'({s2, s1, s0}), 32'b101);
        check("ledge_step_ready", 32'(step_ready), 32'd0);
        step_valid = 1'b1; wr_sym = 3'b000; move = 2'b01;
        tick();
        step_valid = 1'b0;
        check("fault_hold_count", 32'(step_count), 32'd1);
        check("fault_hold_head", 32'(head), 32'd0);
        check("fault_hold_cell0", 32'(dut.cells_q[0]), 32'b101);
`endif

        // Clear via load, then walk to the right edge
        load_en = 1'b1;
        tick();
        check("clr_fault", 32'(edge_fault), 32'd0);
        check("clr_count", 32'(step_count), 32'd0);
        check("clr_load_ready", 32'(load_ready), 32'd1);
        load_en = 1'b0;
        tick();
        step_valid = 1'b1; wr_sym = 3'b010; move = 2'b01;
        repeat (DEPTH - 1) tick();
        check("walk_head", 32'(head), 32'(DEPTH - 1));
        check("walk_count", 32'(step_count), 32'(DEPTH - 1));
        check("walk_sym", 32'({s2, s1, s0}), 32'(pat(15)));
        wr_sym = 3'b011;
        tick();
        step_valid = 1'b0;
        check("redge_count", 32'(step_count), 32'(DEPTH));
        check("redge_cell15", 32'(dut.cells_q[15]), 32'b011);
`ifdef TAPE_WRAP_EN
        check("redge_head", 32'(head), 32'd0);
        check("redge_fault", 32'(edge_fault), 32'd0);
        check("redge_sym", 32'({s2, s1, s0}), 32'b010);
`else
        check("redge_head", 32'(head), 32'(DEPTH - 1));
        check("redge_fault", 32'(edge_fault), 32'd1);
        check("redge_sym", 32'({s2, s1, s0}), 32'b011);
`endif

        // Reset asserted mid-load
        load_en = 1'b1;
        tick();
        load_valid = 1'b1; load_sym = 3'b111;
        tick();
        tick();
        check("pre_rst_cell0", 32'(dut.cells_q[0]), 32'b111);
        #3 rst_n = 1'b0;
        #1;
        any_cell = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            any_cell = any_cell | dut.cells_q[i];
        end
        check("mid_rst_cells", 32'(any_cell), 32'd0);
        check("mid_rst_head", 32'(head), 32'd0);
        check("mid_rst_count", 32'(step_count), 32'd0);
        check("mid_rst_fault", 32'(edge_fault), 32'd0);
        check("mid_rst_sym", 32'({s2, s1, s0}), 32'd0);
        check("mid_rst_load_ready", 32'(load_ready), 32'd0);
        check("mid_rst_step_ready", 32'(step_ready), 32'd0);
        load_en = 1'b0; load_valid = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_step_ready", 32'(step_ready), 32'd1);
        check("post_rst_head", 32'(head), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tape_unit.md
# tape_unit

Tape storage and head controller for the universal Turing machine: holds the tape as an array of 3-bit symbols, presents the symbol under the head on `s2/s1/s0` to the next-state logic, and applies the write-symbol/move command issued each machine step. It supplies the symbol inputs that the next-state logic consumes. A host-side load port fills the tape before a run.

## Interface
Parameters:
- `DEPTH`, 16, number of tape cells; power of two, 4..256
- `ADDR_W`, 4, head/pointer width; must equal log2(`DEPTH`)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `load_en`  in  1  host requests tape load mode
- `load_valid`  in  1  `load_sym` valid this cycle
- `load_sym`  in  3  symbol to append during load
- `load_ready`  out  1  load port accepts a symbol
- `step_valid`  in  1  machine step command valid
- `wr_sym`  in  3  symbol written to the cell under the head
- `move`  in  2  head move: 01 right, 10 left, 00/11 stay
- `step_ready`  out  1  step command accepted this cycle
- `s2`, `s1`, `s0`  out  1 each  symbol under head, MSB..LSB
- `head`  out  `ADDR_W`  current head position
- `edge_fault`  out  1  sticky: head tried to leave the tape
- `step_count`  out  16  accepted steps since last load, saturating

## Operation
- Reset: every cell 000, `head`=0, `{s2,s1,s0}`=000, `step_count`=0, `edge_fault`=0, `load_ready`=0, `step_ready`=0 while `rst_n` low; state RUN afterward.
- States: RUN, LOAD, FAULT.
- RUN: `step_ready` = !`load_en` (combinational). Step transfer = `step_valid && step_ready`: cell[`head`] <= `wr_sym`; `head` moves per `move`; `step_count` += 1, holds at 0xFFFF.
- RUN with `load_en`=1: next state LOAD; `wptr` <= 0; `step_count` <= 0; `edge_fault` <= 0. Load wins over a simultaneous step (step not accepted).
- LOAD: `load_ready` = (`wptr` < `DEPTH`); on `load_valid && load_ready`, cell[`wptr`] <= `load_sym`, `wptr` += 1. After `DEPTH` symbols `load_ready`=0 and further `load_valid` is ignored. Unwritten cells keep prior contents. On `load_en`=0: `head` <= 0, symbol outputs <= cell[0] (including any write in that same cycle), next state RUN.
- Edge: step with move left at `head`=0 or right at `head`=`DEPTH`-1: cell still written, `step_count` increments, `head` unchanged, `edge_fault` <= 1, next state FAULT.
- FAULT: `step_ready`=0, `load_ready`=0; outputs hold. Only `load_en`=1 (-> LOAD, clears fault) or reset exits.
- `{s2,s1,s0}` is registered and always equals cell[`head`] one cycle after any head or cell change; a stay step shows `wr_sym`.
- Reset asserted mid-load or mid-step: immediate return to reset values; partially loaded data discarded (cells cleared).

## Timing
- Step latency 1 cycle: `head`, `{s2,s1,s0}`, `step_count` valid the cycle after the accepting edge; a new step may be accepted every cycle.
- Load throughput 1 symbol/cycle; LOAD->RUN takes 1 cycle after `load_en` falls; first step accepted the following cycle.
- RUN->LOAD takes 1 cycle; `load_ready` high the cycle after `load_en` is sampled.
- All outputs registered except `step_ready` and `load_ready` (decoded from state, `wptr`, `load_en`).

## Configuration
- `TAPE_WRAP_EN` defined: tape is circular; left at 0 goes to `DEPTH`-1, right at `DEPTH`-1 goes to 0; `edge_fault` tied 0, FAULT unreachable.
- Undefined: edge behaviour as in Operation (fault, head held).

## Test plan
- Reset then idle -> `{s2,s1,s0}`=000, `head`=0, `step_count`=0, `step_ready`=1, `load_ready`=0.
- Load 001,010,100, drop `load_en` -> after 1 cycle `head`=0, symbols=001; step (`wr_sym`=111, right) -> `head`=1, symbols=010, cell0=111, `step_count`=1.
- Stay step `wr_sym`=101 -> next cycle symbols=101, `head` unchanged; back-to-back steps every cycle accepted, `step_count` increments each.
- `load_en` and `step_valid` high together in RUN -> `step_ready`=0, no write, LOAD entered, `step_count`=0.
- Left move at `head`=0 -> cell0 written, `head`=0, `edge_fault`=1, `step_ready`=0 until `load_en`; with `TAPE_WRAP_EN` -> `head`=`DEPTH`-1, no fault.
- Load `DEPTH`+2 symbols -> `load_ready` low after `DEPTH`, extra symbols ignored; `rst_n` low mid-load -> all cells 000.
